univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal register: generalises the single-bit D flip-flop
//  to a WIDTH-bit register. Supports load, clear, and multi-cycle
//  shift/rotate operations.
//  A start/busy/done handshake and an internal FSM let an operation shift
//  by a programmable amount, one bit position per clock.
//  Sits between datapath producers and serial/packing logic as the
//  team's general storage/shift element.
// PARAMETERS
//  WIDTH    8   data width in bits (>=2)
//  AMT_W    4   width of shift-amount input
//  RST_VAL  0   value q takes on reset and on CLR (WIDTH bits)
// PORTS
//  clk    in   1        rising-edge clock
//  reset  in   1        asynchronous, active-low reset
//  start  in   1        request an operation; sampled only in IDLE
//  mode   in   3        0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR
//  amt    in   AMT_W    shift/rotate count for modes 2-6
//  d      in   WIDTH    parallel load data (mode 1)
//  sin    in   1        serial fill bit for SHL (into bit 0) and SHR (into MSB)
//  q      out  WIDTH    register contents
//  sout   out  1        last bit shifted/rotated out (registered)
//  busy   out  1        high in RUN and DONE states
//  done   out  1        one-cycle completion pulse
// BEHAVIOUR
//  Reset (reset=0, any time, asynchronous):
//  - Outputs: q=RST_VAL, sout=0, busy=0, done=0.
//  - Internal state: state=IDLE, cnt=0.
//  - Reset mid-operation abandons the operation; no done pulse is issued.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//  - On an edge with start=1: latch mode, sin and d; go to RUN.
//  - cnt <= amt for modes 2-6; cnt <= 1 for modes 0, 1 and 7.
//  RUN, on each edge:
//  - If cnt != 0: apply one step of the latched mode, then cnt <= cnt-1.
//  - If cnt == 0: go to DONE; q is unchanged.
//  Step definitions:
//  - HOLD: q unchanged.
//  - LOAD: q <= latched d.
//  - CLR: q <= RST_VAL.
//  - SHL: q <= {q[W-2:0],sin}; sout <= q[W-1].
//  - SHR: q <= {sin,q[W-1:1]}; sout <= q[0].
//  - ROL/ROR: rotate by one position; sout <= the bit that wrapped around.
//  - ASR: q <= {q[W-1],q[W-1:1]}; sout <= q[0].
//  - sin is the value latched at start; live changes on sin are ignored.
//  - sout changes only on shift/rotate steps.
//  DONE: done=1 for exactly one cycle; next edge -> IDLE.
//  Latency, with start accepted at edge k and N = effective count:
//  - q updates at edges k+1 .. k+N.
//  - done is high during the cycle after edge k+N+1.
//  - Total occupancy is N+2 cycles.
//  Boundary conditions:
//  - amt=0: no step; RUN->DONE at edge k+1; q unchanged.
//  - amt>=WIDTH is legal: shifts run to all-fill; rotates wrap (amt=WIDTH
//    restores q).
//  - start while busy=1 is ignored (not queued).
//  - mode/amt/d changes while busy=1 have no effect.
//  - start held high: a new operation is accepted on the first IDLE edge
//    after DONE.
//  - cnt never underflows.
// TESTING
//  1. Reset: reset=0 asynchronously mid-cycle -> q=RST_VAL, busy=0, done=0
//     immediately, without waiting for a clock edge.
//  2. LOAD d=8'hA5 -> q=8'hA5 at k+1.
//     Then start ROL amt=3 -> q: 4B, 96, 2D; sout=1 at end; done one cycle.
//  3. q=8'h81, ASR amt=2 -> 8'hC0 then 8'hE0.
//     Then SHL sin=1 amt=9 -> q=8'hFF; busy high for 11 cycles.
//  4. amt=0 shift: q unchanged, done pulses 2 cycles after start.
//     Second start during busy is ignored; q and the done count are unaffected.
//  5. Reset asserted during a ROR amt=5 at step 2 -> q=RST_VAL, no done.
//     Then a fresh LOAD works normally.
//  6. CLR with RST_VAL=8'h3C -> q=8'h3C.
//     Random mode/amt sequence checked against a cycle-accurate reference
//     model.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load/clear/hold plus multi-cycle shift and rotate.
// Each shift or rotate step moves one bit position per clock, under a start/busy/done handshake.
module univ_shift_reg #(
   parameter int unsigned         WIDTH   = 8,
   parameter int unsigned         AMT_W   = 4,
   parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'd0;
   localparam logic [2:0] M_LOAD = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_ROL  = 3'd4;
   localparam logic [2:0] M_ROR  = 3'd5;
   localparam logic [2:0] M_ASR  = 3'd6;
   localparam logic [2:0] M_CLR  = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [AMT_W-1:0] r_cnt;
   logic [2:0]       r_mode;
   logic [WIDTH-1:0] r_d;
   logic             r_sin;
   logic [WIDTH-1:0] r_q;
   logic             r_sout;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_step_q;
   logic             w_step_sout;
   logic             w_is_shift;

   // Modes other than HOLD/LOAD/CLR take their step count from amt
   assign w_is_shift = (mode != M_HOLD) && (mode != M_LOAD) && (mode != M_CLR);

   // One step of the latched operation
   always_comb begin
      w_step_q    = r_q;
      w_step_sout = r_sout;
      case (r_mode)
         M_LOAD: w_step_q = r_d;
         M_CLR:  w_step_q = RST_VAL;
         M_SHL: begin
            w_step_q    = {r_q[WIDTH-2:0], r_sin};
            w_step_sout = r_q[WIDTH-1];
         end
         M_SHR: begin
            w_step_q    = {r_sin, r_q[WIDTH-1:1]};
            w_step_sout = r_q[0];
         end
         M_ROL: begin
            w_step_q    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_step_sout = r_q[WIDTH-1];
         end
         M_ROR: begin
            w_step_q    = {r_q[0], r_q[WIDTH-1:1]};
            w_step_sout = r_q[0];
         end
         M_ASR: begin
            w_step_q    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            w_step_sout = r_q[0];
         end
         default: ;
      endcase
   end

   // Control FSM and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mode  <= M_HOLD;
         r_d     <= '0;
         r_sin   <= 1'b0;
         r_q     <= RST_VAL;
         r_sout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode  <= mode;
                  r_d     <= d;
                  r_sin   <= sin;
                  r_cnt   <= w_is_shift ? amt : AMT_W'(1);
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_cnt != '0) begin
                  r_q    <= w_step_q;
                  r_sout <= w_step_sout;
                  r_cnt  <= r_cnt - AMT_W'(1);
               end else begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign q    = r_q;
   assign sout = r_sout;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random operations against an arithmetic reference model.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] mode;
   logic [3:0] amt;
   logic [7:0] d;
   logic       sin;
   logic [7:0] q;
   logic       sout;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   int m_q;
   int m_sout;

   localparam int RST_V = 'h3C;

   univ_shift_reg #(.WIDTH(8), .AMT_W(4), .RST_VAL(8'h3C)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .amt(amt),
      .d(d), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One step of an operation, expressed as integer arithmetic on an 8-bit value
   task automatic model_step(input int m, input int dd, input int s);
      case (m)
         1: m_q = dd;
         2: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + s; end
         3: begin m_sout = m_q % 2;   m_q = m_q / 2 + s * 128; end
         4: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_sout; end
         5: begin m_sout = m_q % 2;   m_q = m_q / 2 + m_sout * 128; end
         6: begin m_sout = m_q % 2;   m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0); end
         7: m_q = RST_V;
         default: ;
      endcase
   endtask

   task automatic scramble_inputs();
      start = 1'($urandom % 2);
      mode  = 3'($urandom);
      amt   = 4'($urandom);
      d     = 8'($urandom);
      sin   = 1'($urandom);
   endtask

   task automatic check_outputs(input string tag, input int exp_busy, input int exp_done);
      check({tag, ".q"},    int'(q),    m_q);
      check({tag, ".sout"}, int'(sout), m_sout);
      check({tag, ".busy"}, int'(busy), exp_busy);
      check({tag, ".done"}, int'(done), exp_done);
   endtask

   // Full operation: accept, N steps (with junk inputs while busy), done cycle, back to idle
   task automatic run_op(input int m, input int a, input int dd, input int s);
      int n;
      start = 1'b1; mode = 3'(m); amt = 4'(a); d = 8'(dd); sin = 1'(s);
      @(posedge clk); #1;
      n = (m >= 2 && m <= 6) ? a : 1;
      for (int i = 0; i < n; i++) begin
         scramble_inputs();
         model_step(m, dd, s);
         @(posedge clk); #1;
         check_outputs("step", 1, 0);
      end
      scramble_inputs();
      @(posedge clk); #1;
      check_outputs("done", 1, 1);
      start = 1'b0;
      @(posedge clk); #1;
      check_outputs("idle", 0, 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; mode = '0; amt = '0; d = '0; sin = 1'b0;
      m_q = RST_V; m_sout = 0;
      #12;
      check_outputs("por", 0, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Async reset mid-cycle after a load
      run_op(1, 0, 'h55, 0);
      #3 reset = 1'b0;
      #1;
      m_q = RST_V; m_sout = 0;
      check_outputs("async_rst", 0, 0);
      @(posedge clk); #1 reset = 1'b1;

      // LOAD then ROL by 3
      run_op(1, 0, 'hA5, 0);
      check("load_a5", int'(q), 'hA5);
      run_op(4, 3, 0, 0);
      check("rol3_q", int'(q), 'h2D);
      check("rol3_sout", int'(sout), 1);

      // ASR by 2, then SHL sin=1 by 9 (over WIDTH)
      run_op(1, 0, 'h81, 0);
      run_op(6, 2, 0, 0);
      check("asr2_q", int'(q), 'hE0);
      run_op(2, 9, 0, 1);
      check("shl9_q", int'(q), 'hFF);

      // amt=0 shift, then ROR by WIDTH restores q
      run_op(3, 0, 0, 1);
      check("amt0_q", int'(q), 'hFF);
      run_op(1, 0, 'h96, 0);
      run_op(5, 8, 0, 0);
      check("ror8_q", int'(q), 'h96);

      // Reset during ROR amt=5 after two steps
      start = 1'b1; mode = 3'd5; amt = 4'd5; d = '0; sin = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      model_step(5, 0, 0);
      @(posedge clk); #1;
      model_step(5, 0, 0);
      @(posedge clk); #1;
      check_outputs("ror_mid", 1, 0);
      #2 reset = 1'b0;
      #1;
      m_q = RST_V; m_sout = 0;
      check_outputs("ror_rst", 0, 0);
      @(posedge clk); #1 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check_outputs("no_done", 0, 0);
      end
      run_op(1, 0, 'h5A, 0);
      check("reload_q", int'(q), 'h5A);

      // CLR returns to RST_VAL
      run_op(7, 0, 0, 0);
      check("clr_q", int'(q), 'h3C);

      // Random operations
      for (int t = 0; t < 40; t++)
         run_op(int'($urandom % 8), int'($urandom % 16), int'($urandom % 256), int'($urandom % 2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
